serial_pattern_gen: RTL and testbench

//  Serial stimulus source for the one-hot sequence detectors: it drives the single-bit w stream the detectors sample.
//  It latches a pattern of up to WIDTH bits and shifts it out LSB-first, one bit per clk.
//  A start/busy/done handshake frames each burst, and an optional auto-repeat inserts a 1-cycle gap between bursts.
//  It sits between the lab control logic (switches/keys) and a detector's w input.

---
 rtl/serial_pattern_gen_pkg.sv | 21 ++
 rtl/serial_pattern_gen_shift_reg.sv | 62 ++++++
 rtl/serial_pattern_gen.sv | 88 ++++++++
 tb/tb_serial_pattern_gen.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/serial_pattern_gen_pkg.sv
// Shared state encoding and helpers for the serial pattern generator.
package serial_pattern_gen_pkg;

    localparam int STATE_W  = 4;
    localparam int IDX_IDLE = 0;
    localparam int IDX_SEND = 1;
    localparam int IDX_GAP  = 2;
    localparam int IDX_DONE = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE = 4'b0001,
        ST_SEND = 4'b0010,
        ST_GAP  = 4'b0100,
        ST_DONE = 4'b1000
    } state_t;

    function automatic int clamp_len(input int len, input int width);
        return (len > width) ? width : len;
    endfunction

endpackage

// File: rtl/serial_pattern_gen_shift_reg.sv
// Shadow + shift register and bit counter; bit0 is the bit to present after the coming edge.
// Single-cycle update on load/reload/shift, no backpressure.
module pattern_shift_reg
    import serial_pattern_gen_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             reload,
    input  logic             shift,
    input  logic [WIDTH-1:0] pattern,
    input  logic [CNT_W-1:0] len,
    output logic             bit0,
    output logic             last
);

    logic [WIDTH-1:0] shadow;
    logic [WIDTH-1:0] sreg;
    logic [WIDTH-1:0] sreg_shr;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] len_q;
    logic [CNT_W-1:0] len_eff;

    assign len_eff  = CNT_W'(clamp_len(int'(len), WIDTH));
    assign sreg_shr = sreg >> 1;
    assign last     = (cnt == len_q - CNT_W'(1));

    // Look-ahead so the top can register w_out in the same edge that updates sreg.
    always_comb begin
        bit0 = sreg[0];
        if (load)
            bit0 = pattern[0];
        else if (reload)
            bit0 = shadow[0];
        else if (shift)
            bit0 = sreg_shr[0];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shadow <= '0;
            sreg   <= '0;
            cnt    <= '0;
            len_q  <= '0;
        end else if (load) begin
            shadow <= pattern;
            sreg   <= pattern;
            len_q  <= len_eff;
            cnt    <= '0;
        end else if (reload) begin
            sreg <= shadow;
            cnt  <= '0;
        end else if (shift) begin
            sreg <= sreg_shr;
            cnt  <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/serial_pattern_gen.sv
// Serial pattern source: shifts a latched pattern out LSB-first; first bit one cycle after start.
// No backpressure: start is ignored while busy, abort returns to IDLE at the next edge.
module serial_pattern_gen
    import serial_pattern_gen_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] pattern,
    input  logic [CNT_W-1:0] len,
    input  logic             rpt,
    input  logic             abort,
    output logic             w_out,
    output logic             w_valid,
    output logic             busy,
    output logic             done
);

    state_t             state;
    logic [STATE_W-1:0] state_nxt;
    logic               is_idle;
    logic               is_send;
    logic               is_gap;
    logic               is_done;
    logic               ok;
    logic               go;
    logic               zero;
    logic               load;
    logic               reload;
    logic               shift;
    logic               bit0;
    logic               last;

    assign is_idle = state[IDX_IDLE];
    assign is_send = state[IDX_SEND];
    assign is_gap  = state[IDX_GAP];
    assign is_done = state[IDX_DONE];
    assign zero    = (len == '0);
    assign busy    = ~is_idle;

    // An illegal (non one-hot) state vector falls back to IDLE like an abort.
    always_comb begin
        state_nxt = '0;
        ok        = ~abort & $onehot(state);
        go        = ok & is_idle & start;
        load      = go;
        reload    = ok & is_gap;
        shift     = ok & is_send;

        state_nxt[IDX_IDLE] = ~ok | (is_idle & ~start) | is_done;
        state_nxt[IDX_SEND] = (go & ~zero) | (ok & is_send & ~last) | reload;
        state_nxt[IDX_GAP]  = ok & is_send & last & rpt;
        state_nxt[IDX_DONE] = (go & zero) | (ok & is_send & last & ~rpt);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= ST_IDLE;
            w_out   <= 1'b0;
            w_valid <= 1'b0;
            done    <= 1'b0;
        end else begin
            state   <= state_t'(state_nxt);
            w_valid <= state_nxt[IDX_SEND];
            w_out   <= state_nxt[IDX_SEND] & bit0;
            done    <= state_nxt[IDX_DONE];
        end
    end

    pattern_shift_reg #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_shift (
        .clk     (clk),
        .reset   (reset),
        .load    (load),
        .reload  (reload),
        .shift   (shift),
        .pattern (pattern),
        .len     (len),
        .bit0    (bit0),
        .last    (last)
    );

endmodule

// File: tb/tb_serial_pattern_gen.sv
// Bench for serial_pattern_gen: directed cycle table, corner sequences, then random traffic against a queue model.
module tb_serial_pattern_gen;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [7:0] pattern;
    logic [3:0] len;
    logic       rpt;
    logic       abort;
    logic       w_out;
    logic       w_valid;
    logic       busy;
    logic       done;
    logic [3:0] obs;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    serial_pattern_gen #(.WIDTH(8), .CNT_W(4)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .pattern (pattern),
        .len     (len),
        .rpt     (rpt),
        .abort   (abort),
        .w_out   (w_out),
        .w_valid (w_valid),
        .busy    (busy),
        .done    (done)
    );

    assign obs = {w_out, w_valid, busy, done};

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: the expected future cycles of the current activity as a queue.
    typedef struct packed {
        logic vld;
        logic b;
        logic bsy;
        logic dn;
        logic last;
    } rec_t;

    function automatic rec_t mk(input logic vld, input logic b, input logic bsy,
                                input logic dn, input logic last);
        rec_t r;
        r.vld = vld; r.b = b; r.bsy = bsy; r.dn = dn; r.last = last;
        return r;
    endfunction

    rec_t       q[$];
    rec_t       cur;
    logic [7:0] m_pat;
    int         m_len;
    logic [3:0] m_exp;

    always @(posedge clk or posedge reset) begin
        if (reset || abort) begin
            q.delete();
            cur = '0;
        end else begin
            if (cur.last) begin
                if (rpt) begin
                    q.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b0));
                    for (int i = 0; i < m_len; i++)
                        q.push_back(mk(1'b1, m_pat[i], 1'b1, 1'b0, i == m_len - 1));
                end else begin
                    q.push_back(mk(1'b0, 1'b0, 1'b1, 1'b1, 1'b0));
                end
            end
            if (!cur.bsy && start) begin
                m_pat = pattern;
                m_len = (len > 4'd8) ? 8 : int'(len);
                if (m_len == 0)
                    q.push_back(mk(1'b0, 1'b0, 1'b1, 1'b1, 1'b0));
                for (int i = 0; i < m_len; i++)
                    q.push_back(mk(1'b1, m_pat[i], 1'b1, 1'b0, i == m_len - 1));
            end
            cur = (q.size() > 0) ? q.pop_front() : rec_t'(0);
        end
    end

    assign m_exp = {cur.b & cur.vld, cur.vld, cur.bsy, cur.dn};

    // Each row: check expected {w_out,w_valid,busy,done} at this negedge, then drive the inputs.
    typedef struct {
        logic [3:0] exp;
        logic       start;
        logic [7:0] pat;
        logic [3:0] len;
        logic       rpt;
        logic       abort;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t row(input logic [3:0] exp, input logic s, input logic [7:0] p,
                                 input logic [3:0] l, input logic r, input logic a);
        vec_t v;
        v.exp = exp; v.start = s; v.pat = p; v.len = l; v.rpt = r; v.abort = a;
        return v;
    endfunction

    task automatic drive(input logic s, input logic [7:0] p, input logic [3:0] l,
                         input logic r, input logic a);
        start = s; pattern = p; len = l; rpt = r; abort = a;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] got;
        int         n;
        int         ndone;

        // basic burst 0B/len4
        tbl.push_back(row(4'b0000, 1, 8'h0B, 4'd4, 0, 0));
        tbl.push_back(row(4'b1110, 0, 8'h00, 4'd0, 0, 0));
        tbl.push_back(row(4'b1110, 0, 8'h00, 4'd0, 0, 0));
        tbl.push_back(row(4'b0110, 0, 8'h00, 4'd0, 0, 0));
        tbl.push_back(row(4'b1110, 0, 8'h00, 4'd0, 0, 0));
        tbl.push_back(row(4'b0011, 0, 8'h00, 4'd0, 0, 0));
        // repeat 06/len3, rpt dropped during second burst
        tbl.push_back(row(4'b0000, 1, 8'h06, 4'd3, 1, 0));
        tbl.push_back(row(4'b0110, 0, 8'h00, 4'd0, 1, 0));
        tbl.push_back(row(4'b1110, 0, 8'h00, 4'd0, 1, 0));
        tbl.push_back(row(4'b1110, 0, 8'h00, 4'd0, 1, 0));
        tbl.push_back(row(4'b0010, 0, 8'h00, 4'd0, 1, 0));
        tbl.push_back(row(4'b0110, 0, 8'h00, 4'd0, 0, 0));
        tbl.push_back(row(4'b1110, 0, 8'h00, 4'd0, 0, 0));
        tbl.push_back(row(4'b1110, 0, 8'h00, 4'd0, 0, 0));
        tbl.push_back(row(4'b0011, 0, 8'h00, 4'd0, 0, 0));
        // zero length
        tbl.push_back(row(4'b0000, 1, 8'hFF, 4'd0, 0, 0));
        tbl.push_back(row(4'b0011, 0, 8'h00, 4'd0, 0, 0));
        // start while busy is ignored
        tbl.push_back(row(4'b0000, 1, 8'h05, 4'd3, 0, 0));
        tbl.push_back(row(4'b1110, 1, 8'hFF, 4'd8, 0, 0));
        tbl.push_back(row(4'b0110, 0, 8'h00, 4'd0, 0, 0));
        tbl.push_back(row(4'b1110, 0, 8'h00, 4'd0, 0, 0));
        tbl.push_back(row(4'b0011, 0, 8'h00, 4'd0, 0, 0));
        // abort on second bit, then a fresh burst
        tbl.push_back(row(4'b0000, 1, 8'hFF, 4'd8, 0, 0));
        tbl.push_back(row(4'b1110, 0, 8'h00, 4'd0, 0, 0));
        tbl.push_back(row(4'b1110, 0, 8'h00, 4'd0, 0, 1));
        tbl.push_back(row(4'b0000, 0, 8'h00, 4'd0, 0, 0));
        tbl.push_back(row(4'b0000, 1, 8'h03, 4'd2, 0, 0));
        tbl.push_back(row(4'b1110, 0, 8'h00, 4'd0, 0, 0));
        tbl.push_back(row(4'b1110, 0, 8'h00, 4'd0, 0, 0));
        tbl.push_back(row(4'b0011, 0, 8'h00, 4'd0, 0, 0));
        // abort together with start in IDLE
        tbl.push_back(row(4'b0000, 1, 8'hFF, 4'd8, 0, 1));
        tbl.push_back(row(4'b0000, 0, 8'h00, 4'd0, 0, 0));
        tbl.push_back(row(4'b0000, 0, 8'h00, 4'd0, 0, 0));

        reset = 1'b1;
        drive(0, 8'h00, 4'd0, 0, 0);
        repeat (2) @(negedge clk);
        chk("reset_state", {4'b0, obs}, 8'h00);
        reset = 1'b0;

        foreach (tbl[i]) begin
            @(negedge clk);
            chk($sformatf("vec%0d", i), {4'b0, obs}, {4'b0, tbl[i].exp});
            drive(tbl[i].start, tbl[i].pat, tbl[i].len, tbl[i].rpt, tbl[i].abort);
        end

        // len above WIDTH clamps to 8 bits
        @(negedge clk);
        drive(1, 8'hA5, 4'd12, 0, 0);
        got = '0; n = 0; ndone = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (w_valid) begin
                if (n < 8) got[n] = w_out;
                n++;
            end
            if (done) ndone++;
            drive(0, 8'h00, 4'd0, 0, 0);
        end
        chk("clamp_count", 8'(n), 8'd8);
        chk("clamp_bits", got, 8'hA5);
        chk("clamp_done", 8'(ndone), 8'd1);

        // asynchronous reset mid-burst
        drive(1, 8'hFF, 4'd8, 0, 0);
        @(negedge clk);
        drive(0, 8'h00, 4'd0, 0, 0);
        repeat (2) @(negedge clk);
        chk("pre_reset_send", {4'b0, obs}, 8'h0E);
        reset = 1'b1;
        #1;
        chk("reset_async", {4'b0, obs}, 8'h00);
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_idle", {4'b0, obs}, 8'h00);

        // randomized traffic against the model
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            chk("rand", {4'b0, obs}, {4'b0, m_exp});
            reset   = ($urandom_range(0, 299) == 0);
            start   = ($urandom_range(0, 3) == 0);
            pattern = 8'($urandom);
            len     = 4'($urandom_range(0, 15));
            rpt     = ($urandom_range(0, 2) == 0);
            abort   = ($urandom_range(0, 49) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
